// File: rtl/mux4_arbiter_pkg.sv
// Purpose: shared encodings and helpers for the 4-way round-robin arbiter.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package mux4_arbiter_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // First set request bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  // Scans from the far end back so the closest offset overwrites last.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req_vec,
                                               input logic [SEL_W-1:0]   ptr);
    logic [SEL_W-1:0] idx;
    rr_pick = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ptr + SEL_W'(k);
      if (req_vec[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/mux4_arbiter_mux4x1.sv
// Purpose: single-bit 4:1 multiplexer, binary select {sel1, sel0}.
// Latency: combinational.
// Backpressure: none.
module mux4_arbiter_mux4x1 (
  input  logic i_d0,
  input  logic i_d1,
  input  logic i_d2,
  input  logic i_d3,
  input  logic i_sel1,
  input  logic i_sel0,
  output logic o_y
);

  // Pick one of four data bits by the 2-bit select.
  always_comb begin
    o_y = i_d0;
    case ({i_sel1, i_sel0})
      2'b00: o_y = i_d0;
      2'b01: o_y = i_d1;
      2'b10: o_y = i_d2;
      2'b11: o_y = i_d3;
      default: o_y = i_d0;
    endcase
  end

endmodule

// File: rtl/mux4_arbiter.sv
// Purpose: 4-requester round-robin arbiter with registered one-hot grant and 4:1 data select.
// Latency: req -> grant 1 cycle; owner hand-off on release with zero idle cycles.
// Backpressure: owner holds while its req stays high; ARB_TIMEOUT_EN adds a MAX_HOLD forced release.
module mux4_arbiter
  import mux4_arbiter_pkg::*;
#(
  parameter int DW       = 1,
  parameter int MAX_HOLD = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [DW-1:0]      in0,
  input  logic [DW-1:0]      in1,
  input  logic [DW-1:0]      in2,
  input  logic [DW-1:0]      in3,
  output logic [NUM_REQ-1:0] grant,
  output logic               sel1,
  output logic               sel0,
  output logic [DW-1:0]      out,
  output logic               out_valid
);

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_max_hold_range
    $error("mux4_arbiter: MAX_HOLD must be in 1..255");
  end

  state_e             r_state;
  state_e             w_state_nxt;
  logic [NUM_REQ-1:0] r_grant;
  logic [NUM_REQ-1:0] w_grant_nxt;
  logic [SEL_W-1:0]   r_sel;
  logic [SEL_W-1:0]   w_sel_nxt;
  logic [SEL_W-1:0]   r_ptr;
  logic [SEL_W-1:0]   w_ptr_nxt;
  logic [SEL_W-1:0]   w_scan_ptr;
  logic [SEL_W-1:0]   w_pick;
  logic               w_timeout;
  logic               w_release;
  logic [DW-1:0]      w_mux_dat;

  // While busy the next winner is searched from owner+1, i.e. the pointer value a release stores.
  assign w_scan_ptr = (r_state == ST_BUSY) ? r_sel + 2'd1 : r_ptr;
  assign w_pick     = rr_pick(req, w_scan_ptr);
  assign w_release  = (r_state == ST_BUSY) && (!req[r_sel] || w_timeout);

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);

  logic [7:0] r_hold_cnt;
  logic [7:0] w_hold_cnt_nxt;

  // Counter holds the number of edges already spent by the owner; the edge at which
  // it reaches MAX_HOLD-1 is the owner's last held cycle if anyone else is waiting.
  assign w_timeout = (r_hold_cnt >= HOLD_LIM) && |(req & ~r_grant);

  // Hold counter: clear on any grant change or when idle, otherwise count up and saturate.
  always_comb begin
    w_hold_cnt_nxt = r_hold_cnt;
    if ((w_grant_nxt != r_grant) || (r_state == ST_IDLE)) begin
      w_hold_cnt_nxt = '0;
    end else if (r_hold_cnt != 8'hFF) begin
      w_hold_cnt_nxt = r_hold_cnt + 8'd1;
    end
  end

  // Hold counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold_cnt <= '0;
    end else begin
      r_hold_cnt <= w_hold_cnt_nxt;
    end
  end
`else
  // No timeout: the owner keeps the grant for as long as it requests.
  assign w_timeout = 1'b0;
`endif

  // State register: FSM state, grant, select and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_sel   <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_sel   <= w_sel_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // Next-state: grant from idle, or release and hand off to the next requester in the same edge.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_sel_nxt   = r_sel;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      ST_IDLE: begin
        if (|req) begin
          w_state_nxt = ST_BUSY;
          w_grant_nxt = NUM_REQ'(1) << w_pick;
          w_sel_nxt   = w_pick;
        end
      end
      ST_BUSY: begin
        if (w_release) begin
          w_ptr_nxt = w_scan_ptr;
          if (|req) begin
            w_grant_nxt = NUM_REQ'(1) << w_pick;
            w_sel_nxt   = w_pick;
          end else begin
            // sel keeps the last owner index; only the grant drops.
            w_state_nxt = ST_IDLE;
            w_grant_nxt = '0;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  for (genvar b = 0; b < DW; b++) begin : g_bit
    mux4_arbiter_mux4x1 u_mux (
      .i_d0   (in0[b]),
      .i_d1   (in1[b]),
      .i_d2   (in2[b]),
      .i_d3   (in3[b]),
      .i_sel1 (r_sel[1]),
      .i_sel0 (r_sel[0]),
      .o_y    (w_mux_dat[b])
    );
  end

  assign grant = r_grant;
  assign sel1  = r_sel[1];
  assign sel0  = r_sel[0];

  // Output: selected data is gated to zero whenever nobody holds the grant.
  always_comb begin
    out_valid = |r_grant;
    out       = out_valid ? w_mux_dat : '0;
  end

endmodule

// File: tb/tb_mux4_arbiter.sv
// Purpose: directed self-checking bench for mux4_arbiter (DW=3, MAX_HOLD=4).
// Latency: inputs driven 1ns after a rising edge, outputs sampled 1ns after the next.
// Backpressure: n/a; timeout expectations follow ARB_TIMEOUT_EN.
module tb_mux4_arbiter;

  localparam int DW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    req = 4'b0000;
  logic [DW-1:0] in0 = '0;
  logic [DW-1:0] in1 = '0;
  logic [DW-1:0] in2 = '0;
  logic [DW-1:0] in3 = '0;
  logic [3:0]    grant;
  logic          sel1;
  logic          sel0;
  logic [DW-1:0] out;
  logic          out_valid;

  logic [DW-1:0] dat [4];

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  mux4_arbiter #(
    .DW       (DW),
    .MAX_HOLD (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .in0       (in0),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .grant     (grant),
    .sel1      (sel1),
    .sel0      (sel0),
    .out       (out),
    .out_valid (out_valid)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] g, input logic [1:0] s,
                         input logic [DW-1:0] o, input logic v);
    chk({tag, ".grant"}, 32'(grant), 32'(g));
    chk({tag, ".sel"},   32'({sel1, sel0}), 32'(s));
    chk({tag, ".out"},   32'(out), 32'(o));
    chk({tag, ".vld"},   32'(out_valid), 32'(v));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_g;

    dat[0] = 3'b001;
    dat[1] = 3'b010;
    dat[2] = 3'b100;
    dat[3] = 3'b111;

    // Reset held with every requester active: nothing may be granted.
    req = 4'b1111;
    in0 = dat[0]; in1 = dat[1]; in2 = dat[2]; in3 = dat[3];
    step();
    chk_all("rst_a", 4'b0000, 2'b00, '0, 1'b0);
    step();
    chk_all("rst_b", 4'b0000, 2'b00, '0, 1'b0);

    // Single requester 2 with in2=1: grant one edge after release of reset.
    in0 = '0; in1 = '0; in2 = 3'b001; in3 = '0;
    req = 4'b0100;
    rst = 1'b0;
    step();
    chk_all("first", 4'b0100, 2'b10, 3'b001, 1'b1);
    req = 4'b0000;
    step();
    chk_all("idle2", 4'b0000, 2'b10, '0, 1'b0);

    // Fresh reset, then all four requesting: 0,1,2,3,0 with no idle gap.
    rst = 1'b1;
    step();
    rst = 1'b0;
    in0 = dat[0]; in1 = dat[1]; in2 = dat[2]; in3 = dat[3];
    req = 4'b1111;
    step();
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 3; c++) begin
        chk_all($sformatf("rr%0d_c%0d", k, c), 4'(1 << k), 2'(k), dat[k], 1'b1);
        if (c < 2) step();
      end
      req = 4'b1111 & ~4'(1 << k);
      step();
      req = 4'b1111;
    end
    chk_all("rr_wrap", 4'b0001, 2'b00, dat[0], 1'b1);

    // Owner 0 drops with only 3 waiting, then 3 hands back to 0 across the wrap.
    req = 4'b1000;
    step();
    chk_all("to3", 4'b1000, 2'b11, dat[3], 1'b1);
    req = 4'b0001;
    step();
    chk_all("wrap30", 4'b0001, 2'b00, dat[0], 1'b1);
    req = 4'b1000;
    step();
    chk_all("to3b", 4'b1000, 2'b11, dat[3], 1'b1);
    req = 4'b0000;
    step();
    chk_all("idle3", 4'b0000, 2'b11, '0, 1'b0);

    // Reset pulsed mid-grant clears grant without waiting for an edge.
    req = 4'b1000;
    step();
    chk_all("pre_rst", 4'b1000, 2'b11, dat[3], 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk_all("async_rst", 4'b0000, 2'b00, '0, 1'b0);
    req = 4'b1010;
    step();
    chk_all("in_rst", 4'b0000, 2'b00, '0, 1'b0);
    rst = 1'b0;
    step();
    chk_all("post_rst", 4'b0010, 2'b01, dat[1], 1'b1);

    // Owner 1 drops; 2 wins and holds while other bits toggle, then alone well past MAX_HOLD.
    req = 4'b0100;
    step();
    chk_all("own2", 4'b0100, 2'b10, dat[2], 1'b1);
    req = 4'b1100;
    step();
    chk("hold_1100", 32'(grant), 32'(4'b0100));
    req = 4'b0101;
    step();
    chk("hold_0101", 32'(grant), 32'(4'b0100));
    req = 4'b1111;
    step();
    chk("hold_1111", 32'(grant), 32'(4'b0100));
    req = 4'b0100;
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("alone_%0d", i), 32'(grant), 32'(4'b0100));
    end
    req = 4'b0000;
    step();
    chk_all("idle4", 4'b0000, 2'b10, '0, 1'b0);

    // Two requesters held continuously: alternate every MAX_HOLD cycles only with the timeout.
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 4'b0011;
    for (int i = 0; i < 12; i++) begin
      step();
`ifdef ARB_TIMEOUT_EN
      exp_g = (((i / 4) % 2) == 0) ? 4'b0001 : 4'b0010;
`else
      exp_g = 4'b0001;
`endif
      chk($sformatf("tmo_%0d", i), 32'(grant), 32'(exp_g));
    end
    req = 4'b0000;
    step();
    chk("tmo_idle", 32'(out_valid), 32'(1'b0));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mux4_arbiter.md
MUX4_ARBITER -- requirements
Module: mux4_arbiter

Interface
REQ-001 Parameter DW, default 1, width of each data input and of out.
REQ-002 Parameter MAX_HOLD, default 15, maximum grant cycles per owner when the timeout is compiled in (range 1..255).
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req  input  4  per-requester request, bit i for requester i, level-sensitive.
REQ-006 in0, in1, in2, in3  input  DW each  requester data into the 4:1 datapath.
REQ-007 grant  output  4  registered one-hot grant, all-zero when idle.
REQ-008 sel1, sel0  output  1 each  registered 4:1 select, binary index of current or last owner.
REQ-009 out  output  DW  selected data: in[sel] when grant is nonzero, else all-zero (combinational from registered sel/grant).
REQ-010 out_valid  output  1  high exactly when grant is nonzero.

Function
REQ-011 FSM with two states, IDLE and BUSY, encoded in 1 bit.
REQ-012 IDLE, req==0: stay IDLE, grant=0.
REQ-013 IDLE, req!=0: next edge enter BUSY, grant = one-hot winner, {sel1,sel0} = winner index; latency req->grant is 1 cycle.
REQ-014 Winner = first set req bit scanning ptr, ptr+1, ptr+2, ptr+3 modulo 4 (wrap 3->0).
REQ-015 ptr is a 2-bit register; on every release it becomes (owner+1) mod 4.
REQ-016 BUSY, req[owner]==1: hold grant and sel unchanged regardless of other requests.
REQ-017 BUSY, req[owner]==0: release; if another req bit set, grant next winner (from updated ptr) on that same edge (zero idle cycles), else return to IDLE with grant=0.
REQ-018 Release never re-grants the releasing owner on the same edge unless it is the only requester and has re-raised req.
REQ-019 sel1/sel0 retain last owner index in IDLE; out is still forced to zero there.
REQ-020 Simultaneous requests on all four bits with ptr=0 grant order 0,1,2,3,0,... as each releases.
REQ-021 Requests changing on non-owner bits never glitch grant; grant changes only on clock edges.

Reset
REQ-022 rst high forces, asynchronously: state=IDLE, grant=4'b0000, sel1=0, sel0=0, ptr=0, hold counter=0, out_valid=0, out=0.
REQ-023 rst asserted mid-grant drops grant immediately; after rst release, arbitration restarts from ptr=0 on the first edge with req!=0.

Configuration
REQ-024 Macro ARB_TIMEOUT_EN: when defined, an 8-bit hold counter counts BUSY cycles of the current owner; reaching MAX_HOLD with any other req bit set forces a release per REQ-017 even if req[owner]=1; counter clears on every grant change.
REQ-025 Without ARB_TIMEOUT_EN: no counter is built, owner holds indefinitely while req[owner]=1, MAX_HOLD is ignored.
REQ-026 With ARB_TIMEOUT_EN and no other requester, owner keeps grant past MAX_HOLD; counter saturates.

Structure
REQ-027 Shared package/header holds state encodings (IDLE, BUSY), requester count (4) and select width (2).
REQ-028 Datapath selection is a sub-module instance of the team's mux4x1 (one per data bit when DW>1), driven by sel1/sel0; grant gating of out is in mux4_arbiter.

Verification
REQ-029 rst=1 with req=4'b1111 -> grant=0000, sel=00, out=0, out_valid=0 throughout reset.
REQ-030 After reset, req=4'b0100, in2=1, other inputs 0 -> one edge later grant=0100, sel=10, out=1, out_valid=1.
REQ-031 req=4'b1111 held, each owner drops its bit for 1 cycle after 3 cycles of grant -> grant sequence 0001,0010,0100,1000,0001 with no idle cycle between owners.
REQ-032 Owner 3 releases with req=4'b0001 pending -> next grant 0001 (ptr wrapped 3->0); owner 3 releasing with req=0 -> IDLE, grant=0000, sel stays 11, out=0.
REQ-033 ARB_TIMEOUT_EN, MAX_HOLD=4, req=4'b0011 held -> grant 0001 for 4 cycles then 0010 for 4 cycles, alternating; without macro -> grant stays 0001.
REQ-034 rst pulsed while grant=1000 -> grant=0000 asynchronously; after release with req=4'b1010 -> grant=0010 (ptr=0).
